// File: rtl/bias_fetch.sv
// Streams num_ch biases from the bias SRAM into the bias buffer, prefetching one ahead.
// Optional BIAS_FETCH_SHIFT_EN adds a latched bias_shift input with saturating left shift.
module bias_fetch #(
  parameter int BIAS_WIDTH = 8,
  parameter int OUT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 10,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_ch,
`ifdef BIAS_FETCH_SHIFT_EN
  input  logic [3:0]            bias_shift,
`endif
  input  logic                  next_ch,
  output logic                  next_rdy,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [BIAS_WIDTH-1:0] mem_rdata,
  output logic                  bias_read,
  output logic [OUT_WIDTH-1:0]  bias_data,
  output logic                  busy,
  output logic                  done
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(MEM_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [CNT_WIDTH-1:0]  num_r;
  logic [CNT_WIDTH-1:0]  fetch_idx;
  logic [CNT_WIDTH-1:0]  ch_cnt;
  logic [LW-1:0]         wait_cnt;
  logic [BIAS_WIDTH-1:0] pf_reg;
  logic                  pf_valid;
  logic [OUT_WIDTH-1:0]  bias_next;
  logic                  accept;
  logic                  xfer;
  logic                  lat_done;

  assign next_rdy = pf_valid;
  assign accept   = start && !busy;
  assign xfer     = next_ch && pf_valid;
  assign lat_done = (wait_cnt == LAT_LAST);

`ifdef BIAS_FETCH_SHIFT_EN
  localparam int WIDE = OUT_WIDTH + 16;
  localparam logic signed [WIDE-1:0] SAT_MAX = (WIDE'(1) << (OUT_WIDTH - 1)) - WIDE'(1);
  localparam logic signed [WIDE-1:0] SAT_MIN = ~SAT_MAX;

  logic [3:0]             shift_r;
  logic signed [WIDE-1:0] shifted;

  // Shift in a 16-bit-wider domain so the clamp sees the true magnitude.
  always_comb begin
    shifted = WIDE'($signed(pf_reg)) <<< shift_r;
    if (shifted > SAT_MAX)
      bias_next = OUT_WIDTH'(SAT_MAX);
    else if (shifted < SAT_MIN)
      bias_next = OUT_WIDTH'(SAT_MIN);
    else
      bias_next = OUT_WIDTH'(shifted);
  end
`else
  always_comb bias_next = OUT_WIDTH'($signed(pf_reg));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    mem_en   = 1'b0;
    mem_addr = '0;
    case (state)
      S_IDLE:  if (accept && num_ch != '0) state_n = S_FETCH;
      S_FETCH: begin
        mem_en   = 1'b1;
        mem_addr = base_r + ADDR_WIDTH'(fetch_idx);
        state_n  = S_WAIT;
      end
      S_WAIT:  if (lat_done) state_n = S_HOLD;
      S_HOLD:  if (xfer) state_n = (fetch_idx < num_r) ? S_FETCH : S_DRAIN;
      S_DRAIN: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_r    <= '0;
      num_r     <= '0;
      fetch_idx <= '0;
      ch_cnt    <= '0;
      wait_cnt  <= '0;
      pf_reg    <= '0;
      pf_valid  <= 1'b0;
      bias_read <= 1'b0;
      bias_data <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef BIAS_FETCH_SHIFT_EN
      shift_r   <= '0;
`endif
    end else begin
      bias_read <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          // busy also covers the single done cycle of an empty layer.
          if (accept) begin
            base_r    <= base_addr;
            num_r     <= num_ch;
            fetch_idx <= '0;
            ch_cnt    <= '0;
            busy      <= 1'b1;
            done      <= (num_ch == '0);
`ifdef BIAS_FETCH_SHIFT_EN
            shift_r   <= bias_shift;
`endif
          end else begin
            busy <= 1'b0;
          end
        end
        S_FETCH: wait_cnt <= '0;
        S_WAIT: begin
          wait_cnt <= wait_cnt + LW'(1);
          if (lat_done) begin
            pf_reg    <= mem_rdata;
            pf_valid  <= 1'b1;
            fetch_idx <= fetch_idx + CNT_WIDTH'(1);
          end
        end
        S_HOLD: begin
          if (xfer) begin
            pf_valid  <= 1'b0;
            bias_read <= 1'b1;
            bias_data <= bias_next;
            ch_cnt    <= ch_cnt + CNT_WIDTH'(1);
            done      <= (ch_cnt == num_r - CNT_WIDTH'(1));
          end
        end
        S_DRAIN: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
